// File: rtl/omp_atom_select_if.sv
// ============================================================================
// Module   : omp_atom_select_if
// Purpose  : Correlation-stream and selection-result bundle for omp_atom_select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface omp_atom_select_if #(
    parameter int DATA_W = 48,
    parameter int IDX_W  = 6
);
    logic                     start;
    logic                     col_valid;
    logic signed [DATA_W-1:0] col_data;
    logic [IDX_W-1:0]         col_idx;
    logic                     scan_done;
    logic                     mask_clear;

    logic                     busy;
    logic                     sel_valid;
    logic [IDX_W-1:0]         best_idx;
    logic [DATA_W-2:0]        best_abs;
    logic                     found;
    logic [IDX_W:0]           sel_count;

    modport master (
        output start, col_valid, col_data, col_idx, scan_done, mask_clear,
        input  busy, sel_valid, best_idx, best_abs, found, sel_count
    );

    modport slave (
        input  start, col_valid, col_data, col_idx, scan_done, mask_clear,
        output busy, sel_valid, best_idx, best_abs, found, sel_count
    );
endinterface

`default_nettype wire

// File: rtl/omp_atom_select.sv
// ============================================================================
// Module   : omp_atom_select
// Purpose  : OMP atom selection - arg-max of |correlation| over one column scan.
//            Optional selected-atom exclusion mask: define OMP_ATOM_SELECT_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module omp_atom_select #(
    parameter int DATA_W    = 48,
    parameter int IDX_W     = 6,
    parameter int NUM_ATOMS = 64
) (
    input  wire                  clk,
    input  wire                  rst_n,
    omp_atom_select_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-2:0] max_abs_q;
    logic [IDX_W-1:0]  max_idx_q;
    logic              hit_q;

    logic              busy_q;
    logic              sel_valid_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [DATA_W-2:0] best_abs_q;
    logic              found_q;

    logic [DATA_W-2:0] max_abs_d;
    logic [IDX_W-1:0]  max_idx_d;
    logic              hit_d;

    logic [DATA_W-1:0] w_neg;
    logic [DATA_W-2:0] w_abs;
    logic              w_in_range;
    logic              w_masked;
    logic              w_accept;
    logic              w_commit;

    assign w_neg      = ~bus.col_data + {{(DATA_W-1){1'b0}}, 1'b1};
    assign w_in_range = ({1'b0, bus.col_idx} < (IDX_W+1)'(NUM_ATOMS));
    assign w_accept   = (state_q == ST_SCAN) && bus.col_valid && w_in_range && !w_masked;
    assign w_commit   = (state_q == ST_SCAN) && !bus.start && bus.scan_done && hit_d;

    // The most negative input has no positive twin; clamp it to the largest magnitude.
    always_comb begin
        w_abs = bus.col_data[DATA_W-2:0];
        if (bus.col_data[DATA_W-1]) begin
            if (w_neg[DATA_W-1]) begin
                w_abs = '1;
            end else begin
                w_abs = w_neg[DATA_W-2:0];
            end
        end
    end

    // Strict greater-than keeps the earliest column on a tie.
    always_comb begin
        max_abs_d = max_abs_q;
        max_idx_d = max_idx_q;
        hit_d     = hit_q;
        if (w_accept && (!hit_q || (w_abs > max_abs_q))) begin
            max_abs_d = w_abs;
            max_idx_d = bus.col_idx;
            hit_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            max_abs_q   <= '0;
            max_idx_q   <= '0;
            hit_q       <= 1'b0;
            busy_q      <= 1'b0;
            sel_valid_q <= 1'b0;
            best_idx_q  <= '0;
            best_abs_q  <= '0;
            found_q     <= 1'b0;
        end else begin
            sel_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q   <= ST_SCAN;
                        busy_q    <= 1'b1;
                        max_abs_q <= '0;
                        max_idx_q <= '0;
                        hit_q     <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (bus.start) begin
                        max_abs_q <= '0;
                        max_idx_q <= '0;
                        hit_q     <= 1'b0;
                    end else begin
                        max_abs_q <= max_abs_d;
                        max_idx_q <= max_idx_d;
                        hit_q     <= hit_d;
                        if (bus.scan_done) begin
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            sel_valid_q <= 1'b1;
                            found_q     <= hit_d;
                            best_idx_q  <= hit_d ? max_idx_d : '0;
                            best_abs_q  <= hit_d ? max_abs_d : '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef OMP_ATOM_SELECT_MASK_EN
    localparam logic [IDX_W:0] c_max_count = (IDX_W+1)'(NUM_ATOMS);

    logic [NUM_ATOMS-1:0] mask_q;
    logic [IDX_W:0]       sel_count_q;

    assign w_masked = w_in_range && mask_q[bus.col_idx];

    // A clear arriving with a commit wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            sel_count_q <= '0;
        end else if (bus.mask_clear) begin
            mask_q      <= '0;
            sel_count_q <= '0;
        end else if (w_commit) begin
            mask_q[max_idx_d] <= 1'b1;
            if (sel_count_q != c_max_count) begin
                sel_count_q <= sel_count_q + 1'b1;
            end
        end
    end

    assign bus.sel_count = sel_count_q;
`else
    logic w_unused_mask;

    assign w_masked      = 1'b0;
    assign w_unused_mask = bus.mask_clear | w_commit;
    assign bus.sel_count = '0;
`endif

    assign bus.busy      = busy_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.best_idx  = best_idx_q;
    assign bus.best_abs  = best_abs_q;
    assign bus.found     = found_q;

endmodule

`default_nettype wire

// File: tb/tb_omp_atom_select.sv
// ============================================================================
// Module   : tb_omp_atom_select
// Purpose  : Directed bench for omp_atom_select with a scan-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_omp_atom_select;
    localparam int DATA_W    = 48;
    localparam int IDX_W     = 6;
    localparam int NUM_ATOMS = 64;
    localparam longint MAXMAG = (64'sd1 <<< (DATA_W-1)) - 1;

`ifdef OMP_ATOM_SELECT_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    omp_atom_select_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    omp_atom_select #(
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .NUM_ATOMS(NUM_ATOMS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: scan-level view ----------------
    typedef struct { longint mag; int idx; } cand_t;
    cand_t             cands[$];
    int                phase;      // 0 idle, 1 scanning, 2 result cycle
    logic [NUM_ATOMS-1:0] m_mask;
    bit                m_valid, m_found;
    int                m_idx, m_count;
    longint            m_abs;

    function automatic longint magnitude(input longint v);
        longint a;
        a = (v < 0) ? -v : v;
        return (a > MAXMAG) ? MAXMAG : a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0; cands.delete(); m_mask = '0;
            m_valid = 0; m_found = 0; m_idx = 0; m_abs = 0; m_count = 0;
        end else begin
            m_valid = 0;
            case (phase)
                0: if (bus.start) begin phase = 1; cands.delete(); end
                1: begin
                    if (bus.start) begin
                        cands.delete();
                    end else begin
                        if (bus.col_valid && int'(bus.col_idx) < NUM_ATOMS && !m_mask[bus.col_idx])
                            cands.push_back('{magnitude(longint'(bus.col_data)), int'(bus.col_idx)});
                        if (bus.scan_done) begin
                            m_found = 0; m_idx = 0; m_abs = 0;
                            foreach (cands[i])
                                if (!m_found || cands[i].mag > m_abs) begin
                                    m_found = 1; m_abs = cands[i].mag; m_idx = cands[i].idx;
                                end
                            if (MASK_EN && m_found) begin
                                m_mask[m_idx] = 1'b1;
                                if (m_count < NUM_ATOMS) m_count++;
                            end
                            m_valid = 1; phase = 2;
                        end
                    end
                end
                default: phase = 0;
            endcase
            if (MASK_EN && bus.mask_clear) begin m_mask = '0; m_count = 0; end
        end
    end

    always @(negedge clk) begin
        chk("busy",      64'(bus.busy),      64'(phase == 1));
        chk("sel_valid", 64'(bus.sel_valid), 64'(m_valid));
        chk("best_idx",  64'(bus.best_idx),  64'(m_idx));
        chk("best_abs",  64'(bus.best_abs),  64'(m_abs));
        chk("found",     64'(bus.found),     64'(m_found));
        chk("sel_count", 64'(bus.sel_count), 64'(m_count));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic cv, input longint d, input int idx,
                       input logic sd, input logic mc = 1'b0);
        @(posedge clk); #2;
        bus.start      = s;
        bus.col_valid  = cv;
        bus.col_data   = d[DATA_W-1:0];
        bus.col_idx    = idx[IDX_W-1:0];
        bus.scan_done  = sd;
        bus.mask_clear = mc;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic result(input string tag, input int idx, input longint mag, input logic fnd);
        idle(); #1;
        chk({tag, ".sel_valid"}, 64'(bus.sel_valid), 64'd1);
        chk({tag, ".busy"},      64'(bus.busy),      64'd0);
        chk({tag, ".best_idx"},  64'(bus.best_idx),  64'(idx));
        chk({tag, ".best_abs"},  64'(bus.best_abs),  64'(mag));
        chk({tag, ".found"},     64'(bus.found),     64'(fnd));
    endtask

    task automatic scan_basic();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1,  5, 0, 0);
        cyc(0, 1, -9, 1, 0);
        cyc(0, 1,  7, 2, 0);
        cyc(0, 1, -9, 3, 0);
        cyc(0, 0,  0, 0, 1);
    endtask

    initial begin
        bus.start = 0; bus.col_valid = 0; bus.col_data = '0;
        bus.col_idx = '0; bus.scan_done = 0; bus.mask_clear = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("reset.sel_valid", 64'(bus.sel_valid), 64'd0);
        chk("reset.best_abs",  64'(bus.best_abs),  64'd0);
        chk("reset.sel_count", 64'(bus.sel_count), 64'd0);

        scan_basic();
        result("scan1", 1, 9, 1);
        chk("scan1.sel_count", 64'(bus.sel_count), MASK_EN ? 64'd1 : 64'd0);

        scan_basic();
        result("scan2", MASK_EN ? 3 : 1, 9, 1);
        chk("scan2.sel_count", 64'(bus.sel_count), MASK_EN ? 64'd2 : 64'd0);

        cyc(0, 0, 0, 0, 0, 1'b1);
        idle(); #1;
        chk("clear.sel_count", 64'(bus.sel_count), 64'd0);
        scan_basic();
        result("scan3", 1, 9, 1);

        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, -(64'sd1 <<< (DATA_W-1)), 4, 0);
        cyc(0, 0, 0, 0, 1);
        result("sat", 4, MAXMAG, 1);

        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        result("empty", 0, 0, 0);

        // Column 4 was committed by the saturation scan when the mask is kept.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 6, 4, 0);
        cyc(0, 0, 0, 0, 1);
        if (MASK_EN) result("masked", 0, 0, 0);
        else         result("masked", 4, 6, 1);

        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 3, 2, 0);
        cyc(0, 1, 11, 5, 1);
        result("simul", 5, 11, 1);

        cyc(0, 0, 0, 0, 0, 1'b1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 20, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 2, 1, 0);
        cyc(0, 0, 0, 0, 1);
        result("abort", 1, 2, 1);

        // start during the result cycle is dropped, so a later scan_done is stray.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 8, 7, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        idle(); #1;
        chk("done_start.sel_valid", 64'(bus.sel_valid), 64'd0);
        chk("done_start.best_idx",  64'(bus.best_idx),  64'd7);

        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 20, 0, 0);
        cyc(0, 1, 30, 2, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        bus.col_valid = 0; bus.scan_done = 1;
        #1;
        chk("rst.busy",      64'(bus.busy),      64'd0);
        chk("rst.best_idx",  64'(bus.best_idx),  64'd0);
        chk("rst.found",     64'(bus.found),     64'd0);
        chk("rst.sel_count", 64'(bus.sel_count), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        bus.scan_done = 0;
        repeat (3) idle();
        #1;
        chk("rst.sel_valid", 64'(bus.sel_valid), 64'd0);
        chk("rst.best_abs",  64'(bus.best_abs),  64'd0);

        @(posedge clk); #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
